// File: rtl/rr_client.sv
// Two-channel job client in front of a round-robin arbiter (job FIFO, beat counter, req/ack FSM).
// Optional per-channel starvation watchdog: define RR_CLIENT_STARVE_WDT_EN.

// Small generic FIFO with head-of-queue peek.
// Latency: pushed entry visible at head_dat_o the cycle after the push edge.
// Backpressure: push ignored when full; caller gates with occupancy.
module rr_client_fifo #(
    parameter int W     = 4,
    parameter int DEPTH = 2
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           push_i,
    input  logic [W-1:0]                   push_dat_i,
    input  logic                           pop_i,
    output logic [W-1:0]                   head_dat_o,
    output logic [$clog2(DEPTH+1)-1:0]     occ_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
    localparam logic [CW-1:0] OCC_FULL = CW'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] occ_q, occ_d;
    logic          do_push, do_pop;

    assign do_push = push_i && (occ_q != OCC_FULL);
    assign do_pop  = pop_i && (occ_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            occ_d = occ_q + 1'b1;
        end else if (do_pop && !do_push) begin
            occ_d = occ_q - 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_dat_i;
            end
        end
    end

    assign head_dat_o = mem_q[rd_ptr_q];
    assign occ_o      = occ_q;
endmodule

// One client channel: 2-deep job FIFO, remaining-beat counter, IDLE/REQ FSM.
// Latency: req rises one cycle after the pop; done pulses the cycle after the final ack.
// Backpressure: job_ready_o low while the FIFO holds two jobs.
module rr_client_chan #(
    parameter int LEN_W     = 4,
    parameter int WDT_LIMIT = 15
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             job_valid_i,
    input  logic [LEN_W-1:0] job_len_i,
    output logic             job_ready_o,
    input  logic             ack_i,
    output logic             req_o,
    output logic             done_o,
    output logic             busy_o,
    output logic             starve_o
);
    typedef enum logic {ST_IDLE, ST_REQ} state_e;

    localparam logic [LEN_W:0] REM_ONE = (LEN_W + 1)'(1);
    localparam logic [LEN_W:0] REM_MAX = {1'b1, {LEN_W{1'b0}}};

    state_e           state_q, state_d;
    logic [LEN_W:0]   rem_q, rem_d;
    logic             done_q, done_d;
    logic             push, pop, fifo_nempty, last_beat;
    logic [LEN_W-1:0] head_len;
    logic [1:0]       occ;
    logic [LEN_W:0]   len_load;

    assign job_ready_o = (occ < 2'd2);
    assign push        = job_valid_i && job_ready_o;
    assign fifo_nempty = (occ != 2'd0);
    assign len_load    = (head_len == '0) ? REM_MAX : {1'b0, head_len};
    assign last_beat   = (state_q == ST_REQ) && ack_i && (rem_q == REM_ONE);

    rr_client_fifo #(.W(LEN_W), .DEPTH(2)) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push_i     (push),
        .push_dat_i (job_len_i),
        .pop_i      (pop),
        .head_dat_o (head_len),
        .occ_o      (occ)
    );

    // Acks arriving while IDLE are trailing grants from the arbiter and fall through untouched.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        pop     = 1'b0;
        done_d  = last_beat;
        if (state_q == ST_IDLE) begin
            if (fifo_nempty) begin
                pop     = 1'b1;
                rem_d   = len_load;
                state_d = ST_REQ;
            end
        end else if (ack_i) begin
            if (rem_q == REM_ONE) begin
                if (fifo_nempty) begin
                    pop   = 1'b1;
                    rem_d = len_load;
                end else begin
                    state_d = ST_IDLE;
                    rem_d   = '0;
                end
            end else begin
                rem_d = rem_q - REM_ONE;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
        end
    end

    assign req_o  = (state_q == ST_REQ);
    assign done_o = done_q;
    // Held through the done cycle so busy drops only once the last job has retired.
    assign busy_o = req_o || fifo_nempty || done_q;

`ifdef RR_CLIENT_STARVE_WDT_EN
    localparam int WDT_W = (WDT_LIMIT > 0) ? $clog2(WDT_LIMIT + 1) : 1;
    localparam logic [WDT_W-1:0] WDT_TOP = WDT_W'(WDT_LIMIT);

    logic [WDT_W-1:0] wdt_q, wdt_d;
    logic             starve_q, starve_d;

    always_comb begin
        wdt_d    = wdt_q;
        starve_d = starve_q;
        if ((state_q != ST_REQ) || ack_i) begin
            wdt_d = '0;
        end else begin
            if (wdt_q != WDT_TOP) begin
                wdt_d = wdt_q + 1'b1;
            end
            if (wdt_d == WDT_TOP) begin
                starve_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wdt_q    <= '0;
            starve_q <= 1'b0;
        end else begin
            wdt_q    <= wdt_d;
            starve_q <= starve_d;
        end
    end

    assign starve_o = starve_q;
`else
    logic unused_wdt_cfg;
    assign unused_wdt_cfg = (WDT_LIMIT != 0);
    assign starve_o       = 1'b0;
`endif
endmodule

// Top: two independent client channels plus a sticky double-grant error flag.
// Latency: per channel as above; proto_err sets the cycle after ack0 && ack1.
// Backpressure: job0_ready/job1_ready reflect each channel's FIFO occupancy.
module rr_client #(
    parameter int LEN_W     = 4,
    parameter int WDT_LIMIT = 15
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             job0_valid,
    input  logic [LEN_W-1:0] job0_len,
    output logic             job0_ready,
    input  logic             job1_valid,
    input  logic [LEN_W-1:0] job1_len,
    output logic             job1_ready,
    input  logic             ack0,
    input  logic             ack1,
    output logic             req0,
    output logic             req1,
    output logic             done0,
    output logic             done1,
    output logic             busy0,
    output logic             busy1,
    output logic             proto_err,
    output logic             starve0,
    output logic             starve1
);
    logic proto_err_q, proto_err_d;

    rr_client_chan #(.LEN_W(LEN_W), .WDT_LIMIT(WDT_LIMIT)) u_ch0 (
        .clock       (clock),
        .reset       (reset),
        .job_valid_i (job0_valid),
        .job_len_i   (job0_len),
        .job_ready_o (job0_ready),
        .ack_i       (ack0),
        .req_o       (req0),
        .done_o      (done0),
        .busy_o      (busy0),
        .starve_o    (starve0)
    );

    rr_client_chan #(.LEN_W(LEN_W), .WDT_LIMIT(WDT_LIMIT)) u_ch1 (
        .clock       (clock),
        .reset       (reset),
        .job_valid_i (job1_valid),
        .job_len_i   (job1_len),
        .job_ready_o (job1_ready),
        .ack_i       (ack1),
        .req_o       (req1),
        .done_o      (done1),
        .busy_o      (busy1),
        .starve_o    (starve1)
    );

    assign proto_err_d = proto_err_q || (ack0 && ack1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            proto_err_q <= 1'b0;
        end else begin
            proto_err_q <= proto_err_d;
        end
    end

    assign proto_err = proto_err_q;
endmodule

// File: tb/tb_rr_client.sv
// Self-checking bench for rr_client: directed sequences plus a per-channel beat scoreboard.
module tb_rr_client;
    localparam int LEN_W     = 4;
    localparam int WDT_LIMIT = 15;

`ifdef RR_CLIENT_STARVE_WDT_EN
    localparam int EXP_STARVE = 1;
`else
    localparam int EXP_STARVE = 0;
`endif

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             job0_valid = 1'b0, job1_valid = 1'b0;
    logic [LEN_W-1:0] job0_len = '0, job1_len = '0;
    logic             ack0 = 1'b0, ack1 = 1'b0;
    logic             job0_ready, job1_ready, req0, req1, done0, done1;
    logic             busy0, busy1, proto_err, starve0, starve1;

    int checks   = 0;
    int failures = 0;
    int exp_q0[$];
    int exp_q1[$];
    int beats0 = 0, beats1 = 0;
    int cyc;

    rr_client #(.LEN_W(LEN_W), .WDT_LIMIT(WDT_LIMIT)) dut (
        .clock      (clock),
        .reset      (reset),
        .job0_valid (job0_valid),
        .job0_len   (job0_len),
        .job0_ready (job0_ready),
        .job1_valid (job1_valid),
        .job1_len   (job1_len),
        .job1_ready (job1_ready),
        .ack0       (ack0),
        .ack1       (ack1),
        .req0       (req0),
        .req1       (req1),
        .done0      (done0),
        .done1      (done1),
        .busy0      (busy0),
        .busy1      (busy1),
        .proto_err  (proto_err),
        .starve0    (starve0),
        .starve1    (starve1)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Scoreboard: expected beat counts queued on acceptance, compared on each done pulse.
    always @(negedge clock) begin
        if (reset) begin
            exp_q0.delete();
            exp_q1.delete();
            beats0 = 0;
            beats1 = 0;
        end else begin
            if (job0_valid && job0_ready) exp_q0.push_back((job0_len == '0) ? (1 << LEN_W) : int'(job0_len));
            if (job1_valid && job1_ready) exp_q1.push_back((job1_len == '0) ? (1 << LEN_W) : int'(job1_len));
            if (done0) begin
                check_eq("sb0_done_has_job", exp_q0.size() > 0, 1);
                if (exp_q0.size() > 0) check_eq("sb0_beats", beats0, exp_q0.pop_front());
                beats0 = 0;
            end
            if (done1) begin
                check_eq("sb1_done_has_job", exp_q1.size() > 0, 1);
                if (exp_q1.size() > 0) check_eq("sb1_beats", beats1, exp_q1.pop_front());
                beats1 = 0;
            end
            if (req0 && ack0) beats0++;
            if (req1 && ack1) beats1++;
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input int ch, input int len);
        if (ch == 0) begin
            job0_valid = 1'b1;
            job0_len   = len[LEN_W-1:0];
        end else begin
            job1_valid = 1'b1;
            job1_len   = len[LEN_W-1:0];
        end
        step();
        job0_valid = 1'b0;
        job1_valid = 1'b0;
    endtask

    // Holds ack high until n_done done pulses are seen; returns cycles spent.
    task automatic ack_until_done(input int ch, input int n_done, output int ncyc);
        int dones;
        dones = 0;
        ncyc  = 0;
        if (ch == 0) ack0 = 1'b1; else ack1 = 1'b1;
        while (dones < n_done && ncyc < 200) begin
            step();
            ncyc++;
            if ((ch == 0) ? done0 : done1) dones++;
        end
        ack0 = 1'b0;
        ack1 = 1'b0;
        check_eq("svc_done_count", dones, n_done);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_outs_low"}, {req0, req1, done0, done1, busy0, busy1, proto_err, starve0, starve1}, 0);
        check_eq({tag, "_ready0"}, job0_ready, 1);
        check_eq({tag, "_ready1"}, job1_ready, 1);
    endtask

    initial begin
        repeat (2) step();
        check_reset_outputs("rst");
        reset = 1'b0;

        // Single job len=3, ack held from req rise.
        push(0, 3);
        check_eq("t1_busy_after_push", busy0, 1);
        check_eq("t1_req_before_pop", req0, 0);
        step();
        check_eq("t1_req_rise", req0, 1);
        ack_until_done(0, 1, cyc);
        check_eq("t1_req_cycles", cyc, 3);
        check_eq("t1_req_low_at_done", req0, 0);
        check_eq("t1_busy_in_done", busy0, 1);
        step();
        check_eq("t1_done_one_cycle", done0, 0);
        check_eq("t1_busy_fall", busy0, 0);

        // Trailing ack while IDLE must not eat a beat of the next loaded job.
        push(0, 1);
        step();
        ack0 = 1'b1;
        job0_valid = 1'b1;
        job0_len = 4'd2;
        step();
        job0_valid = 1'b0;
        check_eq("t2_done_a", done0, 1);
        check_eq("t2_req_low", req0, 0);
        step();
        ack0 = 1'b0;
        check_eq("t2_req_b", req0, 1);
        ack_until_done(0, 1, cyc);
        check_eq("t2_b_cycles", cyc, 2);
        step();

        // Channel 1 back-to-back jobs: FIFO fills, req stays high across reloads.
        push(1, 1);
        check_eq("t3_ready_1", job1_ready, 1);
        push(1, 2);
        check_eq("t3_ready_2", job1_ready, 1);
        check_eq("t3_req1_up", req1, 1);
        push(1, 3);
        check_eq("t3_ready_full", job1_ready, 0);
        job1_valid = 1'b1;
        job1_len = 4'd5;
        step();
        job1_valid = 1'b0;
        check_eq("t3_ready_still_full", job1_ready, 0);
        check_eq("t3_ch0_quiet", {req0, busy0}, 0);
        ack_until_done(1, 3, cyc);
        check_eq("t3_continuous_cycles", cyc, 6);
        check_eq("t3_req1_low", req1, 0);
        step();
        check_eq("t3_busy1_fall", busy1, 0);

        // len=0 encodes 2^LEN_W beats.
        push(0, 0);
        step();
        ack_until_done(0, 1, cyc);
        check_eq("t4_len0_cycles", cyc, 16);
        step();

        // Simultaneous acks: sticky proto_err, no channel effect while idle.
        ack0 = 1'b1;
        ack1 = 1'b1;
        step();
        ack0 = 1'b0;
        ack1 = 1'b0;
        check_eq("t5_proto_err_set", proto_err, 1);
        repeat (3) step();
        check_eq("t5_proto_err_held", proto_err, 1);
        check_eq("t5_no_req", {req0, req1, busy0, busy1}, 0);
        check_eq("t5_sb0_drained", exp_q0.size(), 0);
        check_eq("t5_sb1_drained", exp_q1.size(), 0);

        // Starvation watchdog, then reset mid-job with a queued job.
        push(1, 2);
        push(1, 4);
        check_eq("t6_req1_up", req1, 1);
        repeat (14) step();
        check_eq("t6_starve_before_limit", starve1, 0);
        step();
        check_eq("t6_starve_at_limit", starve1, EXP_STARVE);
        check_eq("t6_starve0_clear", starve0, 0);
        reset = 1'b1;
        #1;
        check_reset_outputs("t6_midjob_rst");
        step();
        reset = 1'b0;
        repeat (4) begin
            step();
            check_eq("t6_no_done_after_rst", {done1, req1, busy1}, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
